// File: rtl/nexys_starship_score_timer.sv
// nexys_starship_score_timer: BCD survival-time score with session high score.
// Counts prescaled ticks while in play, freezes on game over, and latches new highs.
module nexys_starship_score_timer #(
    parameter int TICKS_PER_POINT = 1,
    parameter int PS_W = 8
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        tick,
    input  logic        play_flag,
    input  logic        gameover_ctrl,
    output logic [15:0] score_bcd,
    output logic [15:0] hi_bcd,
    output logic        new_high,
    output logic        saturated,
    output logic        q_ST_Idle,
    output logic        q_ST_Run,
    output logic        q_ST_Over
);
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_OVER = 2'd2} state_t;

    state_t          state_q, state_d;
    logic [15:0]     score_q, score_d, hi_q, hi_d, score_inc;
    logic [PS_W-1:0] ps_q, ps_d;
    logic            new_high_q, new_high_d, sat_q, sat_d, carry;

    always_comb begin
        score_inc = score_q;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                carry = score_q[4*i +: 4] == 4'd9;
                score_inc[4*i +: 4] = carry ? 4'd0 : score_q[4*i +: 4] + 4'd1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        score_d = score_q;
        hi_d = hi_q;
        ps_d = ps_q;
        new_high_d = new_high_q;
        case (state_q)
            ST_IDLE: begin
                if (play_flag && !gameover_ctrl) begin
                    state_d = ST_RUN;
                    score_d = '0;
                    ps_d = '0;
                    new_high_d = 1'b0;
                end
            end
            ST_RUN: begin
                if (gameover_ctrl) begin
                    state_d = ST_OVER;
                    if (score_q > hi_q) begin
                        hi_d = score_q;
                        new_high_d = 1'b1;
                    end
                end else if (!play_flag) begin
                    state_d = ST_IDLE;
                end else if (tick) begin
                    if (ps_q == PS_W'(TICKS_PER_POINT - 1)) begin
                        ps_d = '0;
                        score_d = (score_q == 16'h9999) ? score_q : score_inc;
                    end else begin
                        ps_d = ps_q + PS_W'(1);
                    end
                end
            end
            ST_OVER: state_d = gameover_ctrl ? ST_OVER : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        sat_d = score_d == 16'h9999;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            score_q <= '0;
            hi_q <= '0;
            ps_q <= '0;
            new_high_q <= 1'b0;
            sat_q <= 1'b0;
        end else begin
            state_q <= state_d;
            score_q <= score_d;
            hi_q <= hi_d;
            ps_q <= ps_d;
            new_high_q <= new_high_d;
            sat_q <= sat_d;
        end
    end

    assign score_bcd = score_q;
    assign hi_bcd = hi_q;
    assign new_high = new_high_q;
    assign saturated = sat_q;
    assign q_ST_Run = state_q == ST_RUN;
    assign q_ST_Over = state_q == ST_OVER;
    assign q_ST_Idle = !(q_ST_Run || q_ST_Over);
endmodule

// File: tb/tb_nexys_starship_score_timer.sv
// tb_nexys_starship_score_timer: directed checks of the score timer at 1 and 4 ticks per point.
module tb_nexys_starship_score_timer;
    logic Clk = 1'b0, Reset = 1'b1, tick = 1'b0, play_flag = 1'b0, gameover_ctrl = 1'b0;
    logic [15:0] score_bcd, hi_bcd, score4, hi4;
    logic new_high, saturated, q_ST_Idle, q_ST_Run, q_ST_Over;
    logic nh4, sat4, idle4, run4, over4;
    int checks = 0, passed = 0;

    always #5 Clk = ~Clk;

    nexys_starship_score_timer #(.TICKS_PER_POINT(1)) dut (
        .Clk(Clk), .Reset(Reset), .tick(tick), .play_flag(play_flag), .gameover_ctrl(gameover_ctrl),
        .score_bcd(score_bcd), .hi_bcd(hi_bcd), .new_high(new_high), .saturated(saturated),
        .q_ST_Idle(q_ST_Idle), .q_ST_Run(q_ST_Run), .q_ST_Over(q_ST_Over)
    );

    nexys_starship_score_timer #(.TICKS_PER_POINT(4)) dut4 (
        .Clk(Clk), .Reset(Reset), .tick(tick), .play_flag(play_flag), .gameover_ctrl(gameover_ctrl),
        .score_bcd(score4), .hi_bcd(hi4), .new_high(nh4), .saturated(sat4),
        .q_ST_Idle(idle4), .q_ST_Run(run4), .q_ST_Over(over4)
    );

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic ticks(input int n);
        tick = 1'b1;
        repeat (n) step();
        tick = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        step();
        step();
        checks++; if ({score_bcd, hi_bcd} !== 32'h0) $display("FAIL reset_regs score=%h hi=%h want 0000 0000", score_bcd, hi_bcd); else passed++;
        checks++; if ({new_high, saturated} !== 2'b00) $display("FAIL reset_flags nh=%b sat=%b want 0 0", new_high, saturated); else passed++;
        checks++; if ({q_ST_Idle, q_ST_Run, q_ST_Over} !== 3'b100) $display("FAIL reset_state got %b want 100", {q_ST_Idle, q_ST_Run, q_ST_Over}); else passed++;
        Reset = 1'b0;
        ticks(2);
        checks++; if (score_bcd !== 16'h0000 || q_ST_Idle !== 1'b1) $display("FAIL idle_tick score=%h idle=%b want 0000 1", score_bcd, q_ST_Idle); else passed++;
        play_flag = 1'b1;
        step();
        checks++; if ({q_ST_Idle, q_ST_Run, q_ST_Over} !== 3'b010 || score_bcd !== 16'h0000) $display("FAIL start_run state=%b score=%h want 010 0000", {q_ST_Idle, q_ST_Run, q_ST_Over}, score_bcd); else passed++;
    endtask

    task automatic test_count();
        ticks(1);
        checks++; if (score_bcd !== 16'h0001) $display("FAIL latency score=%h want 0001", score_bcd); else passed++;
        ticks(9);
        checks++; if (score_bcd !== 16'h0010) $display("FAIL count10 score=%h want 0010", score_bcd); else passed++;
        ticks(99);
        checks++; if (score_bcd !== 16'h0109) $display("FAIL count109 score=%h want 0109", score_bcd); else passed++;
        repeat (3) step();
        checks++; if (score_bcd !== 16'h0109) $display("FAIL hold_no_tick score=%h want 0109", score_bcd); else passed++;
        play_flag = 1'b0;
        step();
        checks++; if (q_ST_Idle !== 1'b1 || score_bcd !== 16'h0109 || hi_bcd !== 16'h0000) $display("FAIL play_drop idle=%b score=%h hi=%h want 1 0109 0000", q_ST_Idle, score_bcd, hi_bcd); else passed++;
    endtask

    task automatic test_saturation();
        play_flag = 1'b1;
        step();
        ticks(9998);
        checks++; if (score_bcd !== 16'h9998 || saturated !== 1'b0) $display("FAIL preload score=%h sat=%b want 9998 0", score_bcd, saturated); else passed++;
        ticks(3);
        checks++; if (score_bcd !== 16'h9999 || saturated !== 1'b1) $display("FAIL saturate score=%h sat=%b want 9999 1", score_bcd, saturated); else passed++;
        gameover_ctrl = 1'b1;
        step();
        checks++; if (hi_bcd !== 16'h9999 || new_high !== 1'b1 || saturated !== 1'b1) $display("FAIL sat_over hi=%h nh=%b sat=%b want 9999 1 1", hi_bcd, new_high, saturated); else passed++;
        Reset = 1'b1;
        play_flag = 1'b0;
        gameover_ctrl = 1'b0;
        step();
        Reset = 1'b0;
        checks++; if (hi_bcd !== 16'h0000 || saturated !== 1'b0) $display("FAIL sat_reset hi=%h sat=%b want 0000 0", hi_bcd, saturated); else passed++;
    endtask

    task automatic test_high_score();
        play_flag = 1'b1;
        step();
        ticks(25);
        gameover_ctrl = 1'b1;
        step();
        checks++; if (hi_bcd !== 16'h0025 || new_high !== 1'b1 || q_ST_Over !== 1'b1) $display("FAIL game1_hi hi=%h nh=%b over=%b want 0025 1 1", hi_bcd, new_high, q_ST_Over); else passed++;
        ticks(1);
        checks++; if (score_bcd !== 16'h0025) $display("FAIL over_tick score=%h want 0025", score_bcd); else passed++;
        gameover_ctrl = 1'b0;
        play_flag = 1'b0;
        step();
        play_flag = 1'b1;
        step();
        checks++; if (new_high !== 1'b0 || score_bcd !== 16'h0000 || q_ST_Run !== 1'b1) $display("FAIL game2_start nh=%b score=%h run=%b want 0 0000 1", new_high, score_bcd, q_ST_Run); else passed++;
        ticks(12);
        gameover_ctrl = 1'b1;
        step();
        checks++; if (hi_bcd !== 16'h0025 || new_high !== 1'b0 || score_bcd !== 16'h0012) $display("FAIL game2_over hi=%h nh=%b score=%h want 0025 0 0012", hi_bcd, new_high, score_bcd); else passed++;
        gameover_ctrl = 1'b0;
        play_flag = 1'b0;
        step();
        checks++; if (q_ST_Idle !== 1'b1 || score_bcd !== 16'h0012) $display("FAIL game2_idle idle=%b score=%h want 1 0012", q_ST_Idle, score_bcd); else passed++;
    endtask

    task automatic test_tick_gameover();
        play_flag = 1'b1;
        step();
        ticks(41);
        tick = 1'b1;
        gameover_ctrl = 1'b1;
        step();
        tick = 1'b0;
        checks++; if (score_bcd !== 16'h0041 || hi_bcd !== 16'h0041 || q_ST_Over !== 1'b1) $display("FAIL tick_go score=%h hi=%h over=%b want 0041 0041 1", score_bcd, hi_bcd, q_ST_Over); else passed++;
        gameover_ctrl = 1'b0;
        step();
        checks++; if (q_ST_Idle !== 1'b1) $display("FAIL min_idle idle=%b want 1", q_ST_Idle); else passed++;
        step();
        checks++; if (q_ST_Run !== 1'b1 || score_bcd !== 16'h0000) $display("FAIL restart run=%b score=%h want 1 0000", q_ST_Run, score_bcd); else passed++;
    endtask

    task automatic test_equal_score();
        ticks(41);
        gameover_ctrl = 1'b1;
        step();
        checks++; if (new_high !== 1'b0 || hi_bcd !== 16'h0041) $display("FAIL equal_score nh=%b hi=%h want 0 0041", new_high, hi_bcd); else passed++;
        gameover_ctrl = 1'b0;
        play_flag = 1'b0;
        step();
    endtask

    task automatic test_prescale();
        play_flag = 1'b1;
        step();
        ticks(7);
        checks++; if (score4 !== 16'h0001 || score_bcd !== 16'h0007) $display("FAIL prescale7 s4=%h s1=%h want 0001 0007", score4, score_bcd); else passed++;
        ticks(1);
        checks++; if (score4 !== 16'h0002) $display("FAIL prescale8 s4=%h want 0002", score4); else passed++;
        Reset = 1'b1;
        step();
        checks++; if (score_bcd !== 16'h0000 || hi_bcd !== 16'h0000 || q_ST_Idle !== 1'b1) $display("FAIL midrun_reset score=%h hi=%h idle=%b want 0000 0000 1", score_bcd, hi_bcd, q_ST_Idle); else passed++;
        checks++; if (score4 !== 16'h0000 || hi4 !== 16'h0000 || idle4 !== 1'b1) $display("FAIL midrun_reset4 score=%h hi=%h idle=%b want 0000 0000 1", score4, hi4, idle4); else passed++;
        Reset = 1'b0;
        play_flag = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_count();
        test_saturation();
        test_high_score();
        test_tick_gameover();
        test_equal_score();
        test_prescale();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/nexys_starship_score_timer.md
Name: nexys_starship_score_timer

Overview:
Survival-time score keeper for the starship game. It counts elapsed play time in packed BCD while the game is in Play and freezes the count on game over. It holds a session high score and presents both values as 4-digit BCD, ready to feed the seven-segment scan mux (SSD0..SSD7) in the top level. It consumes game-state signals and a one-cycle time tick generated from DIV_CLK.

Parameters:
TICKS_PER_POINT, 1, number of tick pulses per score increment; legal range 1..255.
PS_W, 8, prescaler counter width; must satisfy 2^PS_W >= TICKS_PER_POINT.

Ports:
Clk  input  1  system clock (sys_clk, 100 MHz)
Reset  input  1  synchronous, active-high reset
tick  input  1  single-Clk-cycle pulse, nominally one per timer_clk period; produced by the top from a DIV_CLK edge detect
play_flag  input  1  level; high while the game SM is in Play
gameover_ctrl  input  1  level; high while the game is over or any monster has ended the game
score_bcd  output  16  current score, packed BCD, digit 3 in [15:12]
hi_bcd  output  16  session high score, packed BCD
new_high  output  1  high when the last finished game set a new high score
saturated  output  1  high when score_bcd = 16'h9999
q_ST_Idle, q_ST_Run, q_ST_Over  output  1 each  one-hot state flags

Behaviour:
- One clock. All registers update on posedge Clk only. Reset is sampled on the clock edge, not asynchronously.
- Reset sets state IDLE, score_bcd=0, hi_bcd=0, new_high=0, saturated=0, and prescaler=0. Reset mid-game discards everything, including hi_bcd.
- State IDLE: score_bcd holds its last value so the final score stays on display. tick is ignored.
  - If play_flag=1 and gameover_ctrl=0, go to RUN. On the same edge: score_bcd<=0, prescaler<=0, new_high<=0, saturated<=0.
- State RUN:
  - gameover_ctrl=1 goes to OVER next edge and has priority over everything else. A tick in that same cycle is dropped (no increment).
  - On that same edge, if score_bcd > hi_bcd then hi_bcd<=score_bcd and new_high<=1. Otherwise both are unchanged.
  - Packed-BCD magnitude equals 16-bit unsigned compare because digits are always valid BCD. Equal scores do not set new_high.
  - Else if tick=1: if prescaler = TICKS_PER_POINT-1, prescaler<=0 and the score increments; otherwise prescaler<=prescaler+1.
  - Score increment is BCD with a ripple carry: digit 9 rolls to 0 and carries to the next digit. There is a 1-cycle latency from the tick to the updated score_bcd.
  - At 9999 the score saturates: further increments are suppressed, score_bcd stays 9999, and saturated=1 (registered with the score).
  - If play_flag drops to 0 without gameover_ctrl (reset of the game SM), go to IDLE. In this case there is no high-score update.
- State OVER: score_bcd, hi_bcd, new_high and saturated are frozen; tick is ignored.
  - gameover_ctrl=0 goes to IDLE. A direct restart needs IDLE first, so there is a minimum 1 cycle in IDLE.
- q_ST_* are decoded from the state register; exactly one is high at all times.
- Illegal state encodings recover to IDLE on the next edge.
- No combinational path from any input to any output.

Test Plan:
- Reset=1 for 2 cycles -> all outputs 0, q_ST_Idle=1. Then play_flag=1 -> q_ST_Run=1 one cycle later, score_bcd=16'h0000.
- TICKS_PER_POINT=1, RUN, 10 ticks -> score_bcd=16'h0010. Then 99 more ticks -> 16'h0109. Each update is visible exactly 1 cycle after its tick.
- Preload via 9998 ticks, then 3 more ticks -> score_bcd=16'h9999, saturated=1, no wrap to 0000.
- Game 1: 25 ticks, then gameover_ctrl=1 -> hi_bcd=16'h0025, new_high=1. Game 2: 12 ticks then game over -> hi_bcd stays 0025, new_high=0, score_bcd shows 0012 in OVER and IDLE.
- tick and gameover_ctrl asserted in the same cycle at score 0041 -> score stays 0041, hi_bcd=0041, q_ST_Over=1.
- TICKS_PER_POINT=4: 7 ticks -> score 0001. Reset asserted mid-RUN -> next edge score_bcd=0, hi_bcd=0, q_ST_Idle=1.
